// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard: per-register load countdown scoreboard that stalls ID bundles reading in-flight load results
module load_use_scoreboard #(
   parameter int ISSUE_W = 2,
   parameter int LOAD_LAT = 2,
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ISSUE_W-1:0]   id_valid,
   input  logic [5*ISSUE_W-1:0] id_rs,
   input  logic [5*ISSUE_W-1:0] id_rt,
   input  logic                 issue_fire,
   input  logic [ISSUE_W-1:0]   issue_ld,
   input  logic [5*ISSUE_W-1:0] issue_dst,
   input  logic                 pipe_hold,
   input  logic                 flush,
   output logic                 stall_o,
   output logic                 busy_o,
   output logic [CNT_W-1:0]     stall_cnt_o
);
   localparam int CW = $clog2(LOAD_LAT + 1);
   logic [CW-1:0] cnt [32];
   logic [CW-1:0] cnt_nxt [32];
   // next countdown: flush clears, hold freezes, else decrement then apply new loads
   always_comb begin
      for (int r = 0; r < 32; r++) begin
         cnt_nxt[r] = cnt[r];
         if (!pipe_hold) cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - CW'(1) : '0;
      end
      if (!pipe_hold && issue_fire)
         for (int s = 0; s < ISSUE_W; s++)
            if (issue_ld[s] && issue_dst[5*s+:5] != 5'd0) cnt_nxt[issue_dst[5*s+:5]] = CW'(LOAD_LAT);
      if (flush)
         for (int r = 0; r < 32; r++) cnt_nxt[r] = '0;
      cnt_nxt[0] = '0;
   end
   // scoreboard state, discarded immediately on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         for (int r = 0; r < 32; r++) cnt[r] <= '0;
      else
         for (int r = 0; r < 32; r++) cnt[r] <= cnt_nxt[r];
   end
   // any register still counting down
   always_comb begin
      busy_o = 1'b0;
      for (int r = 0; r < 32; r++) busy_o = busy_o | (cnt[r] != '0);
   end
   // any valid slot whose nonzero source is still counting down
   always_comb begin
      stall_o = 1'b0;
      for (int s = 0; s < ISSUE_W; s++)
         stall_o = stall_o | (id_valid[s] &
                   ((id_rs[5*s+:5] != 5'd0 && cnt[id_rs[5*s+:5]] != '0) ||
                    (id_rt[5*s+:5] != 5'd0 && cnt[id_rt[5*s+:5]] != '0)));
   end
   // saturating count of cycles actually lost to a stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_cnt_o <= '0;
      else if (stall_o && !pipe_hold && !flush && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
   end
endmodule

// File: tb/tb_load_use_scoreboard.sv
// tb_load_use_scoreboard: vector table, directed corner sequences and random run against a ready-time model
module tb_load_use_scoreboard;
   localparam int IW = 2;
   localparam int LL = 2;
   localparam int CW = 4;
   localparam int SAT = (1 << CW) - 1;
   logic clk, rst;
   logic [IW-1:0] id_valid, issue_ld;
   logic [5*IW-1:0] id_rs, id_rt, issue_dst;
   logic issue_fire, pipe_hold, flush;
   logic stall_o, busy_o;
   logic [CW-1:0] stall_cnt_o;
   int n_cmp = 0;
   int n_err = 0;

   load_use_scoreboard #(.ISSUE_W(IW), .LOAD_LAT(LL), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .issue_fire(issue_fire), .issue_ld(issue_ld), .issue_dst(issue_dst),
      .pipe_hold(pipe_hold), .flush(flush), .stall_o(stall_o), .busy_o(busy_o),
      .stall_cnt_o(stall_cnt_o));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] v;
      logic [9:0] rs, rt;
      logic f;
      logic [1:0] ld;
      logic [9:0] dst;
      logic h, fl;
      logic es, eb;
      int ec;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] v, input logic [9:0] rs, input logic [9:0] rt,
                               input logic f, input logic [1:0] ld, input logic [9:0] dst,
                               input logic h, input logic fl, input logic es, input logic eb, input int ec);
      vec_t x;
      x.v = v; x.rs = rs; x.rt = rt; x.f = f; x.ld = ld; x.dst = dst;
      x.h = h; x.fl = fl; x.es = es; x.eb = eb; x.ec = ec;
      return x;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t x);
      id_valid = x.v; id_rs = x.rs; id_rt = x.rt; issue_fire = x.f;
      issue_ld = x.ld; issue_dst = x.dst; pipe_hold = x.h; flush = x.fl;
   endtask

   task automatic idle();
      drive(mk(2'b00, '0, '0, 1'b0, 2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      #1;
      chk("rst_stall", int'(stall_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      tick();
      chk("rst_cnt", int'(stall_cnt_o), 0);
      rst = 1'b0;
   endtask

   // model: absolute cycle at which each register becomes free
   int cyc;
   int ready_at [32];
   int m_cnt;

   function automatic bit m_busy(input int r);
      return r != 0 && ready_at[r] > cyc;
   endfunction

   function automatic bit m_stall();
      bit st = 0;
      for (int s = 0; s < IW; s++)
         if (id_valid[s] && (m_busy(int'(id_rs[5*s+:5])) || m_busy(int'(id_rt[5*s+:5])))) st = 1;
      return st;
   endfunction

   function automatic bit m_any();
      bit b = 0;
      for (int r = 1; r < 32; r++) if (m_busy(r)) b = 1;
      return b;
   endfunction

   vec_t tbl [13];

   initial begin
      rst = 1'b0;
      idle();
      tbl[0]  = mk(2'b00, '0, '0, 1, 2'b01, {5'd0, 5'd5}, 0, 0, 0, 0, 0);
      tbl[1]  = mk(2'b01, {5'd0, 5'd5}, '0, 0, 2'b00, '0, 0, 0, 1, 1, 0);
      tbl[2]  = mk(2'b01, {5'd0, 5'd5}, '0, 0, 2'b00, '0, 0, 0, 1, 1, 1);
      tbl[3]  = mk(2'b01, {5'd0, 5'd5}, '0, 0, 2'b00, '0, 0, 0, 0, 0, 2);
      tbl[4]  = mk(2'b00, '0, '0, 1, 2'b10, {5'd0, 5'd0}, 0, 0, 0, 0, 2);
      tbl[5]  = mk(2'b10, '0, '0, 0, 2'b00, '0, 0, 0, 0, 0, 2);
      tbl[6]  = mk(2'b00, '0, '0, 1, 2'b11, {5'd7, 5'd3}, 0, 0, 0, 0, 2);
      tbl[7]  = mk(2'b10, {5'd7, 5'd0}, '0, 0, 2'b00, '0, 0, 0, 1, 1, 2);
      tbl[8]  = mk(2'b10, {5'd7, 5'd0}, '0, 0, 2'b00, '0, 0, 0, 1, 1, 3);
      tbl[9]  = mk(2'b00, '0, '0, 1, 2'b11, {5'd7, 5'd3}, 0, 0, 0, 0, 4);
      tbl[10] = mk(2'b01, '0, {5'd0, 5'd3}, 0, 2'b00, '0, 0, 0, 1, 1, 4);
      tbl[11] = mk(2'b01, '0, {5'd0, 5'd3}, 0, 2'b00, '0, 0, 0, 1, 1, 5);
      tbl[12] = mk(2'b01, '0, {5'd0, 5'd3}, 0, 2'b00, '0, 0, 0, 0, 0, 6);
      #2;
      do_reset();
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i]);
         #4;
         chk($sformatf("tbl%0d_stall", i), int'(stall_o), int'(tbl[i].es));
         chk($sformatf("tbl%0d_busy", i), int'(busy_o), int'(tbl[i].eb));
         chk($sformatf("tbl%0d_cnt", i), int'(stall_cnt_o), tbl[i].ec);
         tick();
      end

      // hold extends the stall one cycle per held cycle but is not counted
      do_reset();
      drive(mk(2'b00, '0, '0, 1, 2'b01, {5'd0, 5'd9}, 0, 0, 0, 0, 0));
      tick();
      for (int i = 0; i < 6; i++) begin
         drive(mk(2'b01, {5'd0, 5'd9}, '0, 0, 2'b00, '0, (i >= 1 && i <= 3), 0, 0, 0, 0));
         #4;
         chk($sformatf("hold_stall%0d", i), int'(stall_o), int'(i < 5));
         tick();
      end
      chk("hold_cnt", int'(stall_cnt_o), 2);

      // flush wins over a same-cycle load issue
      do_reset();
      drive(mk(2'b00, '0, '0, 1, 2'b01, {5'd0, 5'd4}, 0, 0, 0, 0, 0));
      tick();
      drive(mk(2'b00, '0, '0, 1, 2'b01, {5'd0, 5'd6}, 0, 1, 0, 0, 0));
      #4;
      chk("flush_pre_busy", int'(busy_o), 1);
      tick();
      drive(mk(2'b11, {5'd6, 5'd4}, {5'd4, 5'd6}, 0, 2'b00, '0, 0, 0, 0, 0, 0));
      #4;
      chk("flush_busy", int'(busy_o), 0);
      chk("flush_stall", int'(stall_o), 0);
      tick();

      // permanent stall saturates the counter, then async reset clears mid-countdown
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(mk(2'b01, {5'd0, 5'd2}, '0, 1, 2'b01, {5'd0, 5'd2}, 0, 0, 0, 0, 0));
         tick();
      end
      chk("sat_cnt", int'(stall_cnt_o), SAT);
      chk("sat_stall", int'(stall_o), 1);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_stall", int'(stall_o), 0);
      chk("arst_busy", int'(busy_o), 0);
      chk("arst_cnt", int'(stall_cnt_o), 0);
      tick();
      rst = 1'b0;

      // random run against the ready-time model
      do_reset();
      cyc = 0;
      m_cnt = 0;
      for (int r = 0; r < 32; r++) ready_at[r] = 0;
      for (int t = 0; t < 3000; t++) begin
         bit st, h, fl;
         id_valid = IW'($urandom);
         issue_ld = IW'($urandom);
         for (int s = 0; s < IW; s++) begin
            id_rs[5*s+:5] = 5'($urandom_range(0, 7));
            id_rt[5*s+:5] = 5'($urandom_range(0, 7));
            issue_dst[5*s+:5] = 5'($urandom_range(0, 7));
         end
         issue_fire = 1'($urandom);
         h = ($urandom_range(0, 7) == 0);
         fl = ($urandom_range(0, 15) == 0);
         pipe_hold = h;
         flush = fl;
         #4;
         st = m_stall();
         chk("rnd_stall", int'(stall_o), int'(st));
         chk("rnd_busy", int'(busy_o), int'(m_any()));
         chk("rnd_cnt", int'(stall_cnt_o), m_cnt);
         if (fl)
            for (int r = 0; r < 32; r++) ready_at[r] = 0;
         else if (h) begin
            for (int r = 1; r < 32; r++) if (m_busy(r)) ready_at[r]++;
         end else if (issue_fire)
            for (int s = 0; s < IW; s++)
               if (issue_ld[s] && issue_dst[5*s+:5] != 0) ready_at[issue_dst[5*s+:5]] = cyc + 1 + LL;
         if (st && !h && !fl && m_cnt < SAT) m_cnt++;
         cyc++;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
